// File: rtl/jesd204_pkg.sv
// +-----------------------------------------------------------------------+
// | jesd204_pkg : shared types and widths for the JESD204 LMFC block       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package jesd204_pkg;

  localparam int c_CNT_W     = 8;
  localparam int c_STRETCH_W = 4;

  typedef enum logic [1:0] {
    WAIT_SYSREF = 2'd0,
    ALIGNED     = 2'd1,
    LOCKED      = 2'd2
  } lmfc_state_t;

endpackage

`default_nettype wire

// File: rtl/jesd204_event_stretch.sv
// +-----------------------------------------------------------------------+
// | jesd204_event_stretch : holds a one-cycle trigger high for STRETCH     |
// | cycles; a retrigger restarts the hold.  Rev 1.0                       |
// +-----------------------------------------------------------------------+
`default_nettype none

module jesd204_event_stretch
  import jesd204_pkg::*;
#(
  parameter logic [c_STRETCH_W-1:0] STRETCH = 4'd4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_trigger,
  output logic o_event
);

  logic [c_STRETCH_W-1:0] r_cnt;
  logic                   r_event;

  // Output is registered so the downstream CDC synchronizer sees a clean level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_event <= 1'b0;
    end else if (i_trigger) begin
      r_cnt   <= STRETCH;
      r_event <= 1'b1;
    end else begin
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - c_STRETCH_W'(1);
      end
      r_event <= (r_cnt > c_STRETCH_W'(1));
    end
  end

  assign o_event = r_event;

endmodule

`default_nettype wire

// File: rtl/jesd204_lmfc.sv
// +-----------------------------------------------------------------------+
// | jesd204_lmfc : LMFC counter aligned to SYSREF, with stretched events. |
// | Optional alignment check: define JESD204_LMFC_ALIGN_CHECK_EN.  Rev 1.0|
// +-----------------------------------------------------------------------+
`default_nettype none

module jesd204_lmfc
  import jesd204_pkg::*;
#(
  parameter int DATA_PATH_WIDTH = 4,
  parameter int EVENT_STRETCH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sysref,
  input  logic [c_CNT_W-1:0] cfg_beats_per_multiframe,
  input  logic [c_CNT_W-1:0] cfg_lmfc_offset,
  input  logic               cfg_sysref_oneshot,
  input  logic               cfg_sysref_disable,
  output logic               lmfc_edge,
  output logic               lmfc_clk,
  output logic [c_CNT_W-1:0] lmfc_counter,
  output logic               sysref_event,
  output logic               align_err_event,
  output logic               aligned
);

  // Stretch length clamped to the legal 1..15; a nonsensical beat width falls back to 1.
  localparam logic [c_STRETCH_W-1:0] c_STRETCH =
    (DATA_PATH_WIDTH < 1)  ? c_STRETCH_W'(1)  :
    (EVENT_STRETCH < 1)    ? c_STRETCH_W'(1)  :
    (EVENT_STRETCH > 15)   ? c_STRETCH_W'(15) :
                             c_STRETCH_W'(EVENT_STRETCH);

  lmfc_state_t        r_state;
  lmfc_state_t        w_state_nxt;
  logic               r_sysref;
  logic               w_sysref_edge;
  logic               w_accept;
  logic [c_CNT_W-1:0] r_lmfc_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               r_lmfc_edge;
  logic               r_lmfc_clk;

  assign w_sysref_edge = sysref & ~r_sysref;
  assign w_accept      = w_sysref_edge & ~cfg_sysref_disable & (r_state != LOCKED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= WAIT_SYSREF;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_SYSREF: begin
        if (w_accept) begin
          w_state_nxt = cfg_sysref_oneshot ? LOCKED : ALIGNED;
        end
      end
      ALIGNED: w_state_nxt = ALIGNED;
      LOCKED:  w_state_nxt = LOCKED;
      default: w_state_nxt = WAIT_SYSREF;
    endcase
  end

  // A SYSREF load wins over the wrap; a shrunk multiframe overflows through 255 to 0.
  always_comb begin
    w_cnt_nxt = r_lmfc_cnt + c_CNT_W'(1);
    if (w_accept) begin
      w_cnt_nxt = (cfg_lmfc_offset > cfg_beats_per_multiframe) ? '0 : cfg_lmfc_offset;
    end else if (r_lmfc_cnt == cfg_beats_per_multiframe) begin
      w_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sysref    <= 1'b0;
      r_lmfc_cnt  <= '0;
      r_lmfc_edge <= 1'b0;
      r_lmfc_clk  <= 1'b0;
    end else begin
      r_sysref    <= sysref;
      r_lmfc_cnt  <= w_cnt_nxt;
      r_lmfc_edge <= (w_cnt_nxt == '0);
      r_lmfc_clk  <= (w_cnt_nxt <= (cfg_beats_per_multiframe >> 1));
    end
  end

  assign lmfc_counter = r_lmfc_cnt;
  assign lmfc_edge    = r_lmfc_edge;
  assign lmfc_clk     = r_lmfc_clk;
  assign aligned      = (r_state != WAIT_SYSREF);

  jesd204_event_stretch #(
    .STRETCH (c_STRETCH)
  ) u_sysref_stretch (
    .clk       (clk),
    .rst       (reset),
    .i_trigger (w_accept),
    .o_event   (sysref_event)
  );

`ifdef JESD204_LMFC_ALIGN_CHECK_EN
  logic w_align_err;

  // Any non-disabled edge after alignment counts, including ones ignored in LOCKED.
  assign w_align_err = w_sysref_edge & ~cfg_sysref_disable &
                       (r_state != WAIT_SYSREF) &
                       (r_lmfc_cnt != cfg_lmfc_offset);

  jesd204_event_stretch #(
    .STRETCH (c_STRETCH)
  ) u_align_err_stretch (
    .clk       (clk),
    .rst       (reset),
    .i_trigger (w_align_err),
    .o_event   (align_err_event)
  );
`else
  assign align_err_event = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_jesd204_lmfc.sv
// +-----------------------------------------------------------------------+
// | tb_jesd204_lmfc : directed self-checking bench for jesd204_lmfc        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_jesd204_lmfc;

`ifdef JESD204_LMFC_ALIGN_CHECK_EN
  localparam logic c_ALIGN_EN = 1'b1;
`else
  localparam logic c_ALIGN_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       sysref;
  logic [7:0] cfg_bpm;
  logic [7:0] cfg_offset;
  logic       cfg_oneshot;
  logic       cfg_disable;
  logic       lmfc_edge;
  logic       lmfc_clk;
  logic [7:0] lmfc_counter;
  logic       sysref_event;
  logic       align_err_event;
  logic       aligned;

  int n_cmp = 0;
  int n_err = 0;

  jesd204_lmfc #(
    .DATA_PATH_WIDTH (4),
    .EVENT_STRETCH   (4)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .sysref                   (sysref),
    .cfg_beats_per_multiframe (cfg_bpm),
    .cfg_lmfc_offset          (cfg_offset),
    .cfg_sysref_oneshot       (cfg_oneshot),
    .cfg_sysref_disable       (cfg_disable),
    .lmfc_edge                (lmfc_edge),
    .lmfc_clk                 (lmfc_clk),
    .lmfc_counter             (lmfc_counter),
    .sysref_event             (sysref_event),
    .align_err_event          (align_err_event),
    .aligned                  (aligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [9:0] pat;
  int         exp_cnt;

  initial begin
    reset       = 1'b1;
    sysref      = 1'b0;
    cfg_bpm     = 8'd7;
    cfg_offset  = 8'd0;
    cfg_oneshot = 1'b0;
    cfg_disable = 1'b0;

    tick(2);
    chk("rst_cnt",   lmfc_counter, 0);
    chk("rst_edge",  lmfc_edge, 0);
    chk("rst_clk",   lmfc_clk, 0);
    chk("rst_evt",   sysref_event, 0);
    chk("rst_align", aligned, 0);
    chk("rst_aerr",  align_err_event, 0);

    // Free run, bpm=7: edge every 8 beats, lmfc_clk high for beats 0..3.
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      exp_cnt = i % 8;
      chk("free_cnt",  lmfc_counter, exp_cnt);
      chk("free_edge", lmfc_edge, (exp_cnt == 0) ? 1 : 0);
      chk("free_clk",  lmfc_clk, (exp_cnt <= 3) ? 1 : 0);
    end
    chk("free_align", aligned, 0);

    // First SYSREF edge while counter=2, offset=5.
    cfg_offset = 8'd5;
    tick(2);
    chk("pre_load_cnt", lmfc_counter, 2);
    sysref = 1'b1;
    tick(1);
    chk("load_cnt",   lmfc_counter, 5);
    chk("load_clk",   lmfc_clk, 0);
    chk("load_evt",   sysref_event, 1);
    chk("load_align", aligned, 1);
    chk("load_aerr",  align_err_event, 0);
    for (int j = 0; j < 3; j++) begin
      tick(1);
      chk("load_evt_hold", sysref_event, 1);
      chk("load_cnt_run",  lmfc_counter, (6 + j) % 8);
    end
    tick(1);
    chk("load_evt_end", sysref_event, 0);
    chk("load_cnt_end", lmfc_counter, 1);
    sysref = 1'b0;

    // Edge coincident with the wrap (counter==bpm), offset=3: load wins, no edge.
    cfg_offset = 8'd3;
    tick(6);
    chk("wrap_pre_cnt", lmfc_counter, 7);
    sysref = 1'b1;
    tick(1);
    chk("wrap_cnt",  lmfc_counter, 3);
    chk("wrap_edge", lmfc_edge, 0);
    chk("wrap_clk",  lmfc_clk, 1);
    chk("wrap_evt",  sysref_event, 1);
    chk("wrap_aerr", align_err_event, c_ALIGN_EN);
    sysref = 1'b0;
    tick(4);
    chk("wrap_evt_end",  sysref_event, 0);
    chk("wrap_aerr_end", align_err_event, 0);
    chk("wrap_cnt_end",  lmfc_counter, 7);

    // Two accepted edges two cycles apart: six contiguous high cycles.
    for (int i = 0; i < 10; i++) begin
      sysref = (i == 0 || i == 2) ? 1'b1 : 1'b0;
      tick(1);
      pat[9-i] = sysref_event;
    end
    chk("retrig_pattern", pat, 10'b1111110000);

    // Reset mid-stretch clears everything immediately.
    sysref = 1'b1;
    tick(1);
    sysref = 1'b0;
    tick(1);
    chk("mid_evt", sysref_event, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_cnt",   lmfc_counter, 0);
    chk("mid_rst_edge",  lmfc_edge, 0);
    chk("mid_rst_clk",   lmfc_clk, 0);
    chk("mid_rst_evt",   sysref_event, 0);
    chk("mid_rst_align", aligned, 0);
    chk("mid_rst_aerr",  align_err_event, 0);
    tick(2);

    // Oneshot: first edge after reset locks, the second is ignored for loading.
    reset       = 1'b0;
    cfg_oneshot = 1'b1;
    cfg_offset  = 8'd5;
    tick(3);
    chk("os_pre_cnt", lmfc_counter, 3);
    chk("os_pre_evt", sysref_event, 0);
    sysref = 1'b1;
    tick(1);
    chk("os_first_cnt",   lmfc_counter, 5);
    chk("os_first_align", aligned, 1);
    chk("os_first_evt",   sysref_event, 1);
    chk("os_first_aerr",  align_err_event, 0);
    sysref = 1'b0;
    tick(4);
    chk("os_gap_cnt", lmfc_counter, 1);
    chk("os_gap_evt", sysref_event, 0);
    sysref = 1'b1;
    tick(1);
    chk("os_second_cnt",  lmfc_counter, 2);
    chk("os_second_evt",  sysref_event, 0);
    chk("os_second_aerr", align_err_event, c_ALIGN_EN);
    sysref = 1'b0;
    tick(3);
    chk("os_aerr_hold", align_err_event, c_ALIGN_EN);
    chk("os_hold_cnt",  lmfc_counter, 5);
    tick(1);
    chk("os_aerr_end", align_err_event, 0);
    chk("os_end_cnt",  lmfc_counter, 6);

    // Disabled edge ignored; out-of-range offset loads 0 and raises lmfc_edge.
    reset = 1'b1;
    tick(1);
    reset       = 1'b0;
    cfg_oneshot = 1'b0;
    cfg_offset  = 8'd9;
    cfg_disable = 1'b1;
    tick(2);
    sysref = 1'b1;
    tick(1);
    chk("dis_cnt",   lmfc_counter, 3);
    chk("dis_align", aligned, 0);
    chk("dis_evt",   sysref_event, 0);
    sysref      = 1'b0;
    cfg_disable = 1'b0;
    tick(1);
    sysref = 1'b1;
    tick(1);
    chk("clamp_cnt",   lmfc_counter, 0);
    chk("clamp_edge",  lmfc_edge, 1);
    chk("clamp_align", aligned, 1);
    chk("clamp_evt",   sysref_event, 1);
    sysref = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
